// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit that stalls E until {hi, lo} is ready
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               mulSigned;
    logic               negQ;
    logic               negR;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    // Operand signs are only meaningful for the signed ops (op_i[0] == 0)
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    assign aNeg = ~op_i[0] & a_i[WIDTH-1];
    assign bNeg = ~op_i[0] & b_i[WIDTH-1];
    assign aMag = aNeg ? -a_i : a_i;
    assign bMag = bNeg ? -b_i : b_i;

    // Multiply on 2*WIDTH extended operands so one multiplier serves both signednesses
    logic [2*WIDTH-1:0] extA;
    logic [2*WIDTH-1:0] extB;
    logic [2*WIDTH-1:0] product;
    assign extA    = {{WIDTH{mulSigned & aReg[WIDTH-1]}}, aReg};
    assign extB    = {{WIDTH{mulSigned & bReg[WIDTH-1]}}, bReg};
    assign product = extA * extB;

    // Restoring step: dividend bits shift out of quo's top as quotient bits shift in
    logic [WIDTH:0]     diff;
    logic               take;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quoNext;
    assign diff    = {rem, quo[WIDTH-1]} - {1'b0, bReg};
    assign take    = ~diff[WIDTH];
    assign remNext = take ? diff[WIDTH-1:0] : {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign quoNext = {quo[WIDTH-2:0], take};

    assign stall_o = start_i & (state != DONE) & ~flush_i & ~rst;
    assign done_o  = (state == DONE);
    assign busy_o  = (state != IDLE);

    // Sequencer, operand latches, divider iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mulSigned <= 1'b0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            aReg      <= '0;
            bReg      <= '0;
            rem       <= '0;
            quo       <= '0;
            hi_o      <= '0;
            lo_o      <= '0;
        end else if (flush_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    mulSigned <= ~op_i[0];
                    negQ      <= aNeg ^ bNeg;
                    negR      <= aNeg;
                    aReg      <= op_i[1] ? aMag : a_i;
                    bReg      <= op_i[1] ? bMag : b_i;
                    rem       <= '0;
                    quo       <= aMag;
                    cnt       <= '0;
                    state     <= op_i[1] ? DIV : MUL;
                end
                MUL: begin
                    hi_o  <= product[2*WIDTH-1:WIDTH];
                    lo_o  <= product[WIDTH-1:0];
                    state <= DONE;
                end
                DIV: begin
                    rem <= remNext;
                    quo <= quoNext;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        hi_o  <= negR ? -remNext : remNext;
                        lo_o  <= negQ ? -quoNext : quoNext;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed checks of mdu_iter against an arithmetic reference
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        done_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int failures = 0;

    mdu_iter #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .busy_o(busy_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // MIPS HI/LO semantics from plain 64-bit arithmetic; returns {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] r;
        logic [63:0] q;
        case (op)
            2'd0: r = sa * sb;
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) r = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    r = {r[31:0], q[31:0]};
                end
            end
            default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return r;
    endfunction

    // Issue one request, scramble operands after acceptance, and check latency, stall count and result
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp = model(op, a, b);
        int cyc = 0;
        int stalls = 0;
        bit got = 0;
        int lat = op[1] ? 33 : 2;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        #1;
        while (cyc < 60 && !got) begin
            if (done_o) got = 1;
            else begin
                stalls += int'(stall_o);
                @(negedge clk);
                if (cyc == 0) begin
                    a_i = $urandom; b_i = $urandom; op_i = 2'($urandom);
                end
                cyc++;
                #1;
            end
        end
        if (!got) begin
            chk({tag, " timeout"}, 64'(cyc), 64'(lat));
            start_i = 1'b0;
            return;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " stalls"}, 64'(stalls), 64'(lat));
        chk({tag, " stallInDone"}, 64'(stall_o), 64'd0);
        chk({tag, " result"}, {hi_o, lo_o}, exp);
        start_i = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, " donePulse"}, {62'd0, done_o, busy_o}, 64'd0);
        chk({tag, " hold"}, {hi_o, lo_o}, exp);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start_i = 1'b1; op_i = 2'd2; a_i = 32'd9; b_i = 32'd3; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("resetOut", {hi_o, lo_o}, 64'd0);
        chk("resetFlags", {61'd0, stall_o, done_o, busy_o}, 64'd0);
        start_i = 1'b0;
        rst = 1'b0;

        runOp("mult", 2'd0, 32'hFFFF_FFFE, 32'd3);
        runOp("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp("div", 2'd2, 32'hFFFF_FFF9, 32'd2);
        runOp("divuZero", 2'd3, 32'd100, 32'd0);
        runOp("divOvf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp("divZeroNeg", 2'd2, 32'hFFFF_FFF0, 32'd0);
        runOp("divNegDen", 2'd2, 32'd17, 32'hFFFF_FFFB);

        // Flush at iteration 10 must leave the previous result untouched
        runOp("prior", 2'd3, 32'd75, 32'd10);
        @(negedge clk);
        start_i = 1'b1; op_i = 2'd3; a_i = 32'hDEAD_BEEF; b_i = 32'd3;
        repeat (11) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flushStall", 64'(stall_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        #1;
        chk("flushBusy", {62'd0, busy_o, done_o}, 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("flushNoDone", {62'd0, busy_o, done_o}, 64'd0);
        chk("flushHold", {hi_o, lo_o}, {32'd5, 32'd7});
        runOp("afterFlush", 2'd1, 32'd6, 32'd7);

        // Flush beats start in IDLE
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'd0;
        #1;
        chk("flushStartStall", 64'(stall_o), 64'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        #1;
        chk("flushStartBusy", 64'(busy_o), 64'd0);

        // Reset mid-divide, with start held through reset
        @(negedge clk);
        start_i = 1'b1; op_i = 2'd3; a_i = 32'd1000; b_i = 32'd7;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstStall", 64'(stall_o), 64'd0);
        @(negedge clk);
        #1;
        chk("rstState", {61'd0, busy_o, done_o, stall_o}, 64'd0);
        chk("rstOut", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        #1;
        chk("rstNoAccept", 64'(busy_o), 64'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 3) rb = 32'd0;
            if (i % 5 == 1) rb = rb >> $urandom_range(31, 16);
            if (i % 7 == 2) ra = ra >> $urandom_range(31, 1);
            runOp("rand", rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Execute-stage multiply/divide responder. The pipeline controller raises a request when the E-stage instruction is MULT, MULTU, DIV or DIVU.
- The unit stalls the pipeline until the result is ready, then presents {hi, lo} for one cycle so the HI/LO write path can capture it.
- Multiply takes 2 cycles. Divide is a 32-iteration radix-2 restoring divider.

Parameters:
- WIDTH, 32, operand width; hi_o and lo_o are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request valid; held high by the pipeline while the instruction sits stalled in E.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled only on acceptance.
- a_i  in  WIDTH  rs operand (multiplicand / dividend).
- b_i  in  WIDTH  rt operand (multiplier / divisor).
- flush_i  in  1  abort the current operation (E-stage flush).
- stall_o  out  1  pipeline must hold E and earlier stages.
- done_o  out  1  one-cycle pulse; hi_o and lo_o hold the new result.
- busy_o  out  1  state is not IDLE.
- hi_o  out  WIDTH  high product, or remainder.
- lo_o  out  WIDTH  low product, or quotient.

Behaviour:
- Reset: synchronous, active-high, dominates every other input.
  - state=IDLE, counter=0, hi_o=0, lo_o=0, done_o=0, busy_o=0.
  - stall_o is forced to 0 while rst=1.
- States: IDLE, MUL, DIV, DONE.
- stall_o (combinational) = start_i & (state==IDLE | state==MUL | state==DIV) & ~flush_i & ~rst.
  - stall_o is 0 in DONE, so the held instruction advances.
- IDLE:
  - start_i=1 and flush_i=0 accepts the request: latch op, a, b at the edge.
  - MULT/MULTU go to MUL. DIV/DIVU go to DIV with counter=0.
- MUL (1 cycle):
  - Compute the 2*WIDTH product: signed for MULT, unsigned for MULTU.
  - At the edge: hi_o=product[2W-1:W], lo_o=product[W-1:0], go to DONE.
- DIV:
  - Operate on magnitudes. For DIV, take the absolute value of negative operands; for DIVU, operands are unsigned.
  - Each cycle: shift the partial remainder left with the next dividend bit, trial-subtract the divisor, keep the result if non-negative, and shift the quotient bit in.
  - The counter increments each cycle. After the iteration with counter=WIDTH-1, apply the sign fix:
    - quotient negated if sign(a) xor sign(b), DIV only;
    - remainder negated if sign(a), DIV only.
  - Load lo_o=quotient and hi_o=remainder, go to DONE.
- DONE: done_o=1 for this cycle only. start_i is ignored here (it is the same instruction). Next state is IDLE.
- Latency, with acceptance at edge T:
  - MUL: done_o high in cycle T+2, stall_o high for 2 cycles.
  - DIV: done_o high in cycle T+WIDTH+1 (T+33), stall_o high for 33 cycles.
- Divide by zero: no exception; full latency still applies.
  - DIVU: result is lo_o=all ones, hi_o=a.
  - DIV: the magnitude result gets the normal sign fix, i.e. lo_o=all ones negated when sign(a)=1 (=1), hi_o=a.
- Signed overflow: DIV of 0x8000_0000 by 0xFFFF_FFFF gives lo_o=0x8000_0000, hi_o=0. This falls out of the magnitude arithmetic with no special case.
- flush_i:
  - In any state, the next state is IDLE and counter=0.
  - No done_o. hi_o and lo_o keep their pre-operation values; they are updated only on entry to DONE.
  - flush_i beats start_i in the same cycle: nothing is accepted.
- Outputs hold value: hi_o and lo_o change only on MUL/DIV completion or reset.
- Back-to-back requests: a new start_i is accepted only in IDLE, so the earliest re-acceptance is the cycle after DONE.
- Operand changes on a_i, b_i and op_i after acceptance have no effect.

Test Plan:
- Reset, then MULT a=0xFFFF_FFFE (-2), b=0x0000_0003 -> stall_o high for 2 cycles; in cycle T+2 done_o=1, hi_o=0xFFFF_FFFF, lo_o=0xFFFF_FFFA.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> hi_o=0xFFFF_FFFE, lo_o=0x0000_0001, done_o in cycle T+2.
- DIV a=-7 (0xFFFF_FFF9), b=2 -> stall_o high for exactly 33 cycles; done_o in cycle T+33; lo_o=0xFFFF_FFFD (-3), hi_o=0xFFFF_FFFF (-1).
- DIVU a=100, b=0 -> lo_o=0xFFFF_FFFF, hi_o=100. DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo_o=0x8000_0000, hi_o=0.
- DIVU started with a prior result of hi=5, lo=7; flush_i pulsed at iteration 10 -> busy_o=0 next cycle, no done_o, hi_o=5 and lo_o=7 unchanged; a new request in the following cycle is accepted.
- rst asserted mid-DIV -> next cycle state IDLE, hi_o=lo_o=0, stall_o=0, done_o=0. A start_i coinciding with rst is not accepted.
